if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Instruction buffer between the IF stage and the ID stage; it replaces the single-entry IF_ID register.
- Captures each fetched instruction/PC pair from IF into a small circular FIFO.
- Presents the oldest pair to ID under a valid/ready handshake.
- Drives back-pressure to IF's `stall_i` and drops all contents on a branch-unit redirect.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- NOP_INST, 32'h00000013, instruction driven on `inst_o` when the queue is empty (addi x0,x0,0).

Ports:
- clk_i  input  1  system clock; all state updates on rising edge.
- rst_i  input  1  reset, asynchronous, active-low (0 = reset).
- inst_i  input  `INST_WIDTH  instruction from IF `inst_o`.
- pc_i  input  `SYS_ADDR_SPACE  PC from IF `pc_o`.
- valid_i  input  1  IF presents a fetched pair this cycle.
- ready_o  output  1  queue can accept a push this cycle.
- stall_o  output  1  equals ~ready_o; wired to IF `stall_i`.
- flush_i  input  1  branch redirect (same signal as IF `pc_we`); discard all entries.
- inst_o  output  `INST_WIDTH  head instruction, or NOP_INST when empty.
- pc_o  output  `SYS_ADDR_SPACE  head PC, or 0 when empty.
- valid_o  output  1  head entry present.
- ready_i  input  1  ID consumes the head this cycle (hazard unit ~stall).
- count_o  output  $clog2(DEPTH)+1  current occupancy, for debug and the hazard unit.

Behaviour:
- State:
  - storage: inst_mem[DEPTH] and pc_mem[DEPTH].
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH.
  - count, $clog2(DEPTH)+1 bits.
- Reset (rst_i=0, async assert, sync-to-clock deassert at the top level):
  - wr_ptr = rd_ptr = count = 0.
  - Outputs: valid_o=0, inst_o=NOP_INST, pc_o=0, ready_o=1, stall_o=0, count_o=0.
  - Storage contents need not be reset.
- Handshake signals:
  - push = valid_i & ready_o & ~flush_i.
  - pop = valid_o & ready_i & ~flush_i.
- ready_o = (count < DEPTH), decoded from registered count only.
  - There is no combinational path from ready_i or valid_i to ready_o.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - IF must hold inst_i/pc_i stable while stalled; the PC module already does this.
- Push: write inst_i/pc_i at wr_ptr; wr_ptr += 1.
- Pop: rd_ptr += 1.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged; legal at any count 1..DEPTH-1.
- Outputs are combinational from registered state:
  - valid_o = (count != 0).
  - inst_o/pc_o = mem[rd_ptr] when valid_o, otherwise NOP_INST/0.
- Latency: a pair pushed at edge N is visible on inst_o/valid_o after edge N. No same-cycle bypass from inst_i to inst_o.
- Flush (flush_i=1 at edge):
  - wr_ptr = rd_ptr = count = 0.
  - Any concurrent valid_i is discarded; it is the wrong-path instruction.
  - Any concurrent ready_i is ignored.
  - ready_o is 1 the following cycle.
- Flush has priority over push and pop. Reset has priority over everything.
- Empty with ready_i=1: no pop, pointers unchanged, ID sees NOP_INST with valid_o=0.
- Full with valid_i=1 and no pop: no write, stall_o=1, state unchanged.
- Reset mid-operation: all entries lost immediately, regardless of clock.
- Pointer wrap: wr_ptr/rd_ptr wrap from DEPTH-1 to 0. Ordering is strictly FIFO across the wrap.

Decomposition:
- Shared defines header (existing):
  - `INST_WIDTH and `SYS_ADDR_SPACE.
  - New `NOP_INST constant (32'h00000013), used as the NOP_INST default and by ID bubble insertion.
- One natural sub-module: if_id_queue_mem.
  - DEPTH x (`INST_WIDTH + `SYS_ADDR_SPACE) register array.
  - One write port, one asynchronous read port.
- Pointer, count and handshake logic stay in the top module.

Test Plan:
- Reset then idle: rst_i=0 for 2 cycles, release, valid_i=0 -> valid_o=0, inst_o=32'h00000013, pc_o=0, ready_o=1, count_o=0.
- Single pass-through: push inst=32'h00500093, pc=32'h0 with ready_i=1 -> next cycle valid_o=1, inst_o=32'h00500093, pc_o=0; following cycle valid_o=0.
- Fill and back-pressure (DEPTH=4): push pcs 0,4,8,C with ready_i=0 -> count_o=4, stall_o=1.
  - Then present pc 0x10: not accepted.
  - Then drain with ready_i=1: outputs 0,4,8,C in order.
  - 0x10 is accepted once ready_o=1.
- Simultaneous push/pop at count=2: count stays 2. Pushing 10 pairs through continuously exercises pointer wrap with order preserved.
- Flush with concurrent push: count=3, flush_i=1 and valid_i=1 (pc 0x40) at the same edge -> count_o=0, valid_o=0 next cycle. A push of pc 0x80 then appears at the head alone.
- Async reset mid-stream: with count=2, drop rst_i between clock edges -> valid_o=0 and count_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// Shared widths and types for the IF/ID instruction queue.
package if_id_queue_pkg;

  localparam int INST_WIDTH     = 32;
  localparam int SYS_ADDR_SPACE = 32;

  // addi x0,x0,0: what ID sees when the queue has nothing to offer.
  localparam logic [INST_WIDTH-1:0] NOP_INST_WORD = 32'h00000013;

  typedef struct packed {
    logic [INST_WIDTH-1:0]     inst;
    logic [SYS_ADDR_SPACE-1:0] pc;
  } entry_t;

endpackage

// File: rtl/if_id_queue_if.sv
// Handshake bundle between IF, the instruction queue and ID.
interface if_id_queue_if
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 4
) ();

  logic [INST_WIDTH-1:0]     inst_i;
  logic [SYS_ADDR_SPACE-1:0] pc_i;
  logic                      valid_i;
  logic                      ready_o;
  logic                      stall_o;
  logic                      flush_i;
  logic [INST_WIDTH-1:0]     inst_o;
  logic [SYS_ADDR_SPACE-1:0] pc_o;
  logic                      valid_o;
  logic                      ready_i;
  logic [$clog2(DEPTH):0]    count_o;

  // Queue side.
  modport slave (
    input  inst_i, pc_i, valid_i, flush_i, ready_i,
    output ready_o, stall_o, inst_o, pc_o, valid_o, count_o
  );

  // IF/ID (environment) side.
  modport master (
    output inst_i, pc_i, valid_i, flush_i, ready_i,
    input  ready_o, stall_o, inst_o, pc_o, valid_o, count_o
  );

endinterface

// File: rtl/if_id_queue_mem.sv
// Register-array storage for the queue: one write port, one async read port.
module if_id_queue_mem
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  entry_t                   wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output entry_t                   rdata
);

  entry_t mem [DEPTH];

  // Write the pushed pair; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// Circular FIFO replacing the IF_ID register: buffers fetched pairs,
// presents the oldest to ID and back-pressures IF when full.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int                    DEPTH    = 4,
  parameter logic [INST_WIDTH-1:0] NOP_INST = NOP_INST_WORD
) (
  input  logic         clk_i,
  input  logic         rst_i,
  if_id_queue_if.slave q
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             ready;
  logic             valid;
  logic             push;
  logic             pop;
  entry_t           wr_entry;
  entry_t           rd_entry;

  // Handshake decode; ready depends on registered count only, so a full
  // queue refuses a push even when ID pops in the same cycle.
  always_comb begin
    ready = (count < CNT_W'(DEPTH));
    valid = (count != '0);
    push  = q.valid_i & ready & ~q.flush_i;
    pop   = valid & q.ready_i & ~q.flush_i;
  end

  assign wr_entry = '{inst: q.inst_i, pc: q.pc_i};

  if_id_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk_i (clk_i),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  // Pointer and occupancy update; flush discards everything including a
  // concurrent wrong-path fetch.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (q.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head presentation: a bubble (NOP, pc 0) whenever the queue is empty.
  always_comb begin
    q.valid_o = valid;
    q.ready_o = ready;
    q.stall_o = ~ready;
    q.count_o = count;
    q.inst_o  = valid ? rd_entry.inst : NOP_INST;
    q.pc_o    = valid ? rd_entry.pc   : '0;
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_if_id_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic clk;
  logic rst_i;

  if_id_queue_if #(.DEPTH(DEPTH)) bus ();

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .q     (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  logic [31:0] m_inst[$];
  logic [31:0] m_pc[$];

  typedef struct {
    logic        v;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fl;
    logic        rdy;
    logic        ev;
    logic [31:0] einst;
    logic [31:0] epc;
    int          ecnt;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle and advance the reference model across the edge.
  task automatic apply(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic fl, input logic rdy);
    bit mpush, mpop;
    bus.valid_i = v;
    bus.inst_i  = inst;
    bus.pc_i    = pc;
    bus.flush_i = fl;
    bus.ready_i = rdy;
    mpush = v && (m_pc.size() < DEPTH) && !fl;
    mpop  = (m_pc.size() > 0) && rdy && !fl;
    @(posedge clk);
    #1;
    if (fl) begin
      m_inst.delete();
      m_pc.delete();
    end else begin
      if (mpop) begin
        void'(m_inst.pop_front());
        void'(m_pc.pop_front());
      end
      if (mpush) begin
        m_inst.push_back(inst);
        m_pc.push_back(pc);
      end
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    n = m_pc.size();
    chk({tag, " valid_o"}, 32'(bus.valid_o), 32'(n != 0));
    chk({tag, " inst_o"},  bus.inst_o, (n != 0) ? m_inst[0] : NOP);
    chk({tag, " pc_o"},    bus.pc_o,   (n != 0) ? m_pc[0]   : 32'h0);
    chk({tag, " count_o"}, 32'(bus.count_o), 32'(n));
    chk({tag, " ready_o"}, 32'(bus.ready_o), 32'(n < DEPTH));
    chk({tag, " stall_o"}, 32'(bus.stall_o), 32'(n >= DEPTH));
  endtask

  initial begin
    logic [31:0] exp_heads[5];
    int          exp_cnts[5];

    bus.valid_i = 1'b0;
    bus.inst_i  = '0;
    bus.pc_i    = '0;
    bus.flush_i = 1'b0;
    bus.ready_i = 1'b0;

    // Reset then idle.
    rst_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    chk("rst valid_o", 32'(bus.valid_o), 32'h0);
    chk("rst inst_o",  bus.inst_o, NOP);
    chk("rst pc_o",    bus.pc_o, 32'h0);
    chk("rst ready_o", 32'(bus.ready_o), 32'h1);
    chk("rst stall_o", 32'(bus.stall_o), 32'h0);
    chk("rst count_o", 32'(bus.count_o), 32'h0);

    // Vector table: inputs for one edge, expected head/occupancy after it.
    tbl[0] = '{1'b1, 32'h00500093, 32'h00, 1'b0, 1'b1, 1'b1, 32'h00500093, 32'h00, 1};
    tbl[1] = '{1'b0, 32'h0,        32'h00, 1'b0, 1'b1, 1'b0, NOP,          32'h00, 0};
    tbl[2] = '{1'b1, 32'h000000aa, 32'h04, 1'b0, 1'b0, 1'b1, 32'h000000aa, 32'h04, 1};
    tbl[3] = '{1'b1, 32'h000000bb, 32'h08, 1'b0, 1'b0, 1'b1, 32'h000000aa, 32'h04, 2};
    tbl[4] = '{1'b1, 32'h000000cc, 32'h0c, 1'b0, 1'b1, 1'b1, 32'h000000bb, 32'h08, 2};
    tbl[5] = '{1'b0, 32'h0,        32'h00, 1'b1, 1'b0, 1'b0, NOP,          32'h00, 0};
    tbl[6] = '{1'b0, 32'h0,        32'h00, 1'b0, 1'b1, 1'b0, NOP,          32'h00, 0};
    for (int i = 0; i < 7; i++) begin
      apply(tbl[i].v, tbl[i].inst, tbl[i].pc, tbl[i].fl, tbl[i].rdy);
      chk($sformatf("vec%0d valid_o", i), 32'(bus.valid_o), 32'(tbl[i].ev));
      chk($sformatf("vec%0d inst_o", i),  bus.inst_o, tbl[i].einst);
      chk($sformatf("vec%0d pc_o", i),    bus.pc_o, tbl[i].epc);
      chk($sformatf("vec%0d count_o", i), 32'(bus.count_o), 32'(tbl[i].ecnt));
    end

    // Fill and back-pressure.
    for (int i = 0; i < 4; i++) apply(1'b1, 32'h100 + 32'(i), 32'(4 * i), 1'b0, 1'b0);
    chk("full count_o", 32'(bus.count_o), 32'h4);
    chk("full stall_o", 32'(bus.stall_o), 32'h1);
    apply(1'b1, 32'h110, 32'h10, 1'b0, 1'b0);
    chk("full refuse count_o", 32'(bus.count_o), 32'h4);
    chk("full refuse pc_o",    bus.pc_o, 32'h0);
    exp_heads = '{32'h4, 32'h8, 32'hc, 32'h10, 32'h0};
    exp_cnts  = '{3, 3, 2, 1, 0};
    for (int i = 0; i < 5; i++) begin
      apply(i < 2, 32'h110, 32'h10, 1'b0, 1'b1);
      chk($sformatf("drain%0d pc_o", i),    bus.pc_o, exp_heads[i]);
      chk($sformatf("drain%0d count_o", i), 32'(bus.count_o), 32'(exp_cnts[i]));
    end
    check_model("drain end");

    // Simultaneous push/pop at count 2 through the pointer wrap.
    apply(1'b1, 32'h200, 32'h200, 1'b0, 1'b0);
    apply(1'b1, 32'h201, 32'h204, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, 32'h300 + 32'(i), 32'h300 + 32'(4 * i), 1'b0, 1'b1);
      chk($sformatf("pp%0d count_o", i), 32'(bus.count_o), 32'h2);
      check_model($sformatf("pp%0d", i));
    end
    apply(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush with a concurrent push.
    for (int i = 0; i < 3; i++) apply(1'b1, 32'h400 + 32'(i), 32'h20 + 32'(4 * i), 1'b0, 1'b0);
    chk("pre-flush count_o", 32'(bus.count_o), 32'h3);
    apply(1'b1, 32'h440, 32'h40, 1'b1, 1'b1);
    chk("flush count_o", 32'(bus.count_o), 32'h0);
    chk("flush valid_o", 32'(bus.valid_o), 32'h0);
    chk("flush ready_o", 32'(bus.ready_o), 32'h1);
    apply(1'b1, 32'h480, 32'h80, 1'b0, 1'b0);
    chk("post-flush pc_o",    bus.pc_o, 32'h80);
    chk("post-flush count_o", 32'(bus.count_o), 32'h1);

    // Async reset between edges.
    apply(1'b1, 32'h481, 32'h84, 1'b0, 1'b0);
    bus.valid_i = 1'b0;
    chk("pre-areset count_o", 32'(bus.count_o), 32'h2);
    #2;
    rst_i = 1'b0;
    #1;
    chk("areset valid_o", 32'(bus.valid_o), 32'h0);
    chk("areset count_o", 32'(bus.count_o), 32'h0);
    chk("areset inst_o",  bus.inst_o, NOP);
    chk("areset ready_o", 32'(bus.ready_o), 32'h1);
    m_inst.delete();
    m_pc.delete();
    #2;
    rst_i = 1'b1;
    apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check_model("after areset");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      apply(1'($urandom_range(0, 3) != 0), $urandom, $urandom & 32'hffff_fffc,
            1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
      check_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
